// File: rtl/player_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : player_input_ctrl_if
// Description : Bundles one player's raw button inputs with the tick-aligned
//               command outputs that feed player_move.
// Revision    : 1.0 - initial release
// ============================================================================
interface player_input_ctrl_if;
    logic btn_left_raw;
    logic btn_right_raw;
    logic btn_attack_raw;
    logic SCEN;
    logic move_left;
    logic move_right;
    logic attack_req;
    logic dash;

    // Board side: drives buttons, observes commands
    modport master (
        output btn_left_raw, btn_right_raw, btn_attack_raw,
        input  SCEN, move_left, move_right, attack_req, dash
    );

    // Controller side: samples buttons, produces commands
    modport slave (
        input  btn_left_raw, btn_right_raw, btn_attack_raw,
        output SCEN, move_left, move_right, attack_req, dash
    );
endinterface
`default_nettype wire

// File: rtl/player_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_input_ctrl
// Description : Synchronises and debounces one player's buttons, generates
//               the game-tick strobe SCEN and presents tick-aligned movement
//               commands, an attack request and (optionally) a dash pulse.
//               Optional dash detection is enabled by defining PLAYER_DASH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module player_input_ctrl #(
    parameter int unsigned TICK_DIV    = 1666667,
    parameter int unsigned TICK_W      = 21,
    parameter int unsigned DB_CYCLES   = 500000,
    parameter int unsigned DB_W        = 19,
    parameter int unsigned DASH_WINDOW = 12
) (
    input  wire logic          clk,
    input  wire logic          reset,
    player_input_ctrl_if.slave bus
);

    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   c_db_last   = DB_W'(DB_CYCLES - 1);

    // Bit 0 = left, bit 1 = right, bit 2 = attack
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_db;

    assign w_raw = {bus.btn_attack_raw, bus.btn_right_raw, bus.btn_left_raw};

    // Two-flop synchroniser for the asynchronous button levels
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic            r_db;
        logic [DB_W-1:0] r_cnt;

        // Accept a new level only after DB_CYCLES consecutive disagreeing samples
        always_ff @(posedge clk) begin
            if (reset) begin
                r_db  <= 1'b0;
                r_cnt <= '0;
            end else if (r_sync2[g] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_db_last) begin
                r_db  <= r_sync2[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_db[g] = r_db;
    end

    logic [TICK_W-1:0] r_tcnt;
    logic              w_tick_end;
    logic              r_scen;

    assign w_tick_end = (r_tcnt == c_tick_last);

    // Free-running tick divider; SCEN follows the terminal count by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
            r_scen <= 1'b0;
        end else begin
            r_tcnt <= w_tick_end ? '0 : r_tcnt + 1'b1;
            r_scen <= w_tick_end;
        end
    end

    logic r_db_a_d;
    logic w_rise_a;
    logic r_atk_pend;
    logic r_atk_req;
    logic r_move_left;
    logic r_move_right;

    assign w_rise_a = w_db[2] & ~r_db_a_d;

    // Latch movement on the tick edge; collect attack presses between ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_a_d     <= 1'b0;
            r_atk_pend   <= 1'b0;
            r_atk_req    <= 1'b0;
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
        end else begin
            r_db_a_d <= w_db[2];
            if (w_tick_end) begin
                r_move_left  <= w_db[0] & ~w_db[1];
                r_move_right <= w_db[1] & ~w_db[0];
                r_atk_req    <= r_atk_pend | w_rise_a;
                r_atk_pend   <= 1'b0;
            end else begin
                r_atk_req <= 1'b0;
                if (w_rise_a) begin
                    r_atk_pend <= 1'b1;
                end
            end
        end
    end

`ifdef PLAYER_DASH_EN
    localparam int unsigned AGE_W = $clog2(DASH_WINDOW + 2);
    localparam logic [AGE_W-1:0] c_age_win = AGE_W'(DASH_WINDOW);
    localparam logic [AGE_W-1:0] c_age_max = AGE_W'(DASH_WINDOW + 1);

    logic             r_db_l_d;
    logic             r_db_r_d;
    logic             w_rise_l;
    logic             w_rise_r;
    logic             w_dash_set;
    logic [AGE_W-1:0] r_age_l;
    logic [AGE_W-1:0] r_age_r;
    logic             r_dash_pend;
    logic             r_dash;

    assign w_rise_l   = w_db[0] & ~r_db_l_d;
    assign w_rise_r   = w_db[1] & ~r_db_r_d;
    assign w_dash_set = (w_rise_l & ~w_rise_r & (r_age_l <= c_age_win)) |
                        (w_rise_r & ~w_rise_l & (r_age_r <= c_age_win));

    // Track ticks since each direction's last press; an opposite press
    // forgets the other direction. Ages start saturated so the first press
    // after reset is never treated as the second half of a dash.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_l_d <= 1'b0;
            r_db_r_d <= 1'b0;
            r_age_l  <= c_age_max;
            r_age_r  <= c_age_max;
        end else begin
            r_db_l_d <= w_db[0];
            r_db_r_d <= w_db[1];
            if (w_rise_l && w_rise_r) begin
                r_age_l <= c_age_max;
                r_age_r <= c_age_max;
            end else if (w_rise_l) begin
                r_age_l <= '0;
                r_age_r <= c_age_max;
            end else if (w_rise_r) begin
                r_age_r <= '0;
                r_age_l <= c_age_max;
            end else if (w_tick_end) begin
                if (r_age_l != c_age_max) r_age_l <= r_age_l + 1'b1;
                if (r_age_r != c_age_max) r_age_r <= r_age_r + 1'b1;
            end
        end
    end

    // Hold a detected dash until the next tick edge, then pulse it once
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dash_pend <= 1'b0;
            r_dash      <= 1'b0;
        end else if (w_tick_end) begin
            r_dash      <= r_dash_pend | w_dash_set;
            r_dash_pend <= 1'b0;
        end else begin
            r_dash <= 1'b0;
            if (w_dash_set) begin
                r_dash_pend <= 1'b1;
            end
        end
    end

    assign bus.dash = r_dash;
`else
    assign bus.dash = 1'b0;
`endif

    assign bus.SCEN       = r_scen;
    assign bus.move_left  = r_move_left;
    assign bus.move_right = r_move_right;
    assign bus.attack_req = r_atk_req;

endmodule
`default_nettype wire

// File: tb/tb_player_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_input_ctrl
// Description : Directed self-checking bench for player_input_ctrl with
//               TICK_DIV=10, DB_CYCLES=4, DASH_WINDOW=3. Dash scenarios are
//               compiled in when PLAYER_DASH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_input_ctrl;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    player_input_ctrl_if bus ();

    player_input_ctrl #(
        .TICK_DIV    (10),
        .TICK_W      (4),
        .DB_CYCLES   (4),
        .DB_W        (3),
        .DASH_WINDOW (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock; observation point is 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold reset for three edges, check the reset state, then release.
    // The interval that follows the last reset-high edge is cycle 0.
    task automatic do_reset();
        reset              = 1'b1;
        bus.btn_left_raw   = 1'b0;
        bus.btn_right_raw  = 1'b0;
        bus.btn_attack_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scen",   bus.SCEN,       1'b0);
        chk("rst_left",   bus.move_left,  1'b0);
        chk("rst_right",  bus.move_right, 1'b0);
        chk("rst_attack", bus.attack_req, 1'b0);
        chk("rst_dash",   bus.dash,       1'b0);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;

        // Idle: SCEN every 10 cycles, one cycle wide, everything else low
        do_reset();
        while (cyc <= 31) begin
            chk("idle_scen",   bus.SCEN, (cyc != 0) && (cyc % 10 == 0));
            chk("idle_left",   bus.move_left,  1'b0);
            chk("idle_right",  bus.move_right, 1'b0);
            chk("idle_attack", bus.attack_req, 1'b0);
            chk("idle_dash",   bus.dash,       1'b0);
            step();
        end

        // Left raised at cycle 3: debounced at 9, latched on the tick at 10
        do_reset();
        while (cyc <= 25) begin
            bus.btn_left_raw = (cyc >= 3);
            chk("left_cmd",   bus.move_left,  cyc >= 10);
            chk("left_other", bus.move_right, 1'b0);
            step();
        end

        // Right raised at cycle 4: debounced at 10, misses tick 10, caught at 20
        do_reset();
        while (cyc <= 25) begin
            bus.btn_right_raw = (cyc >= 4);
            chk("right_late",  bus.move_right, cyc >= 20);
            chk("right_other", bus.move_left,  1'b0);
            step();
        end

        // 3-cycle pulses on right are glitches and never get through
        do_reset();
        while (cyc <= 40) begin
            bus.btn_right_raw = ((cyc % 6) < 3);
            chk("glitch_right", bus.move_right, 1'b0);
            step();
        end

        // Left held, right added at 10: left for one tick, then neither
        do_reset();
        while (cyc <= 35) begin
            bus.btn_left_raw  = 1'b1;
            bus.btn_right_raw = (cyc >= 10);
            chk("both_left",  bus.move_left,  (cyc >= 10) && (cyc < 20));
            chk("both_right", bus.move_right, 1'b0);
            step();
        end

        // Two attack presses debounced at 21 and 29 merge into one request at 30;
        // a long hold from 35 gives one request at 50 and no repeat at 60
        do_reset();
        while (cyc <= 65) begin
            bus.btn_attack_raw = ((cyc >= 15) && (cyc <= 18)) ||
                                 ((cyc >= 23) && (cyc <= 26)) ||
                                 (cyc >= 35);
            chk("attack", bus.attack_req, (cyc == 30) || (cyc == 50));
            step();
        end

        // Attack pending when reset hits is discarded
        do_reset();
        while (cyc <= 8) begin
            bus.btn_attack_raw = (cyc < 6);
            step();
        end
        do_reset();
        while (cyc <= 25) begin
            chk("attack_after_rst", bus.attack_req, 1'b0);
            step();
        end

`ifdef PLAYER_DASH_EN
        // Presses debounced at 6, 26 (age 2 -> dash at 30), 76 (age saturated),
        // then a press at 96 left pending when reset asserts
        do_reset();
        while (cyc <= 98) begin
            bus.btn_left_raw = (cyc <= 4) ||
                               ((cyc >= 20) && (cyc <= 24)) ||
                               ((cyc >= 70) && (cyc <= 74)) ||
                               ((cyc >= 90) && (cyc <= 94));
            chk("dash", bus.dash, cyc == 30);
            if (cyc == 30) chk("dash_left", bus.move_left, 1'b1);
            step();
        end
        do_reset();
        while (cyc <= 25) begin
            chk("dash_after_rst", bus.dash, 1'b0);
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
